// File: rtl/nbit_seqdiv.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_seqdiv
//  Description : Signed WIDTH-bit restoring divider, one iteration per clock.
//                Truncating quotient, remainder follows the dividend's sign.
//  Revision    : 1.0 - initial release
// ============================================================================
module nbit_seqdiv #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err
);

    localparam int               c_cw   = $clog2(WIDTH);
    localparam logic [c_cw-1:0]  c_last = c_cw'(WIDTH - 1);
    localparam logic [c_cw-1:0]  c_one  = c_cw'(1);
    localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_neg1 = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [c_cw-1:0]  r_cnt;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_orig;
    logic             r_dz;
    logic             r_ovf;

    logic             w_accept;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_fit;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dvs_abs = divisor[WIDTH-1]  ? -divisor  : divisor;

    // One extra guard bit above the partial remainder so the trial result's MSB is its sign.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = w_shift - {2'b00, r_dvs};
    assign w_fit   = ~w_trial[WIDTH+1];

    assign w_q_fix = r_qneg ? -r_quo : r_quo;
    assign w_r_fix = r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_orig    <= '0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dvd  <= w_dvd_abs;
                r_dvs  <= w_dvs_abs;
                r_rem  <= '0;
                r_quo  <= '0;
                r_cnt  <= '0;
                r_qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                r_rneg <= dividend[WIDTH-1];
                r_orig <= dividend;
                r_dz   <= (divisor == '0);
                r_ovf  <= (dividend == c_min) && (divisor == c_neg1);
            end

            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end

                S_CALC: begin
                    r_rem <= w_fit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_fit};
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        r_state <= S_SIGN;
                    end
                end

                S_SIGN: begin
                    // Divide-by-zero still runs the full iteration count; its results are overridden here.
                    if (r_dz) begin
                        quotient  <= '0;
                        remainder <= r_orig;
                        err       <= 1'b1;
                    end else if (r_ovf) begin
                        quotient  <= c_min;
                        remainder <= '0;
                        err       <= 1'b1;
                    end else begin
                        quotient  <= w_q_fix;
                        remainder <= w_r_fix;
                        err       <= 1'b0;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end

                S_DONE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nbit_seqdiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nbit_seqdiv
//  Description : Self-checking bench for nbit_seqdiv at WIDTH=6 and WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_seqdiv;

    logic        clk;
    logic        rst;

    logic        start6, busy6, done6, err6;
    logic [5:0]  dvd6, dvs6, q6, r6;
    logic        start16, busy16, done16, err16;
    logic [15:0] dvd16, dvs16, q16, r16;

    int total = 0;
    int bad   = 0;

    nbit_seqdiv #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .dividend(dvd6), .divisor(dvs6),
        .busy(busy6), .done(done6), .quotient(q6), .remainder(r6), .err(err6)
    );

    nbit_seqdiv #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dvd16), .divisor(dvs16),
        .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .err(err16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer division, C-style truncation, masked to w bits.
    function automatic void ref_div(input int a, input int b, input int w,
                                    output int q, output int r, output int e);
        int mn;
        mn = -(1 << (w - 1));
        if (b == 0) begin
            q = 0; r = a; e = 1;
        end else if (a == mn && b == -1) begin
            q = mn; r = 0; e = 1;
        end else begin
            q = a / b; r = a % b; e = 0;
        end
        q = q & ((1 << w) - 1);
        r = r & ((1 << w) - 1);
    endfunction

    task automatic go6(input int a, input int b);
        @(negedge clk);
        start6 = 1'b1; dvd6 = 6'(a); dvs6 = 6'(b);
        @(negedge clk);
        start6 = 1'b0; dvd6 = 6'($urandom); dvs6 = 6'($urandom);
    endtask

    task automatic wait6(output int lat, output int bc);
        lat = 0; bc = 0;
        while (done6 !== 1'b1 && lat < 64) begin
            if (busy6 === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic go16(input int a, input int b);
        @(negedge clk);
        start16 = 1'b1; dvd16 = 16'(a); dvs16 = 16'(b);
        @(negedge clk);
        start16 = 1'b0; dvd16 = 16'($urandom); dvs16 = 16'($urandom);
    endtask

    task automatic wait16(output int lat);
        lat = 0;
        while (done16 !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        total++; if ({busy6, done6, err6, q6, r6} !== 15'd0) begin
            bad++; $display("FAIL reset6 got busy=%0b done=%0b err=%0b q=%h r=%h want all 0", busy6, done6, err6, q6, r6);
        end
        total++; if ({busy16, done16, err16, q16, r16} !== 35'd0) begin
            bad++; $display("FAIL reset16 got busy=%0b done=%0b err=%0b q=%h r=%h want all 0", busy16, done16, err16, q16, r16);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bc;
        go6(13, 4);
        wait6(lat, bc);
        total++; if (lat !== 7) begin bad++; $display("FAIL basic_latency got %0d want 7", lat); end
        total++; if (bc !== 7) begin bad++; $display("FAIL basic_busy_cycles got %0d want 7", bc); end
        total++; if (busy6 !== 1'b0) begin bad++; $display("FAIL basic_busy_with_done got %0b want 0", busy6); end
        total++; if ({q6, r6, err6} !== {6'd3, 6'd1, 1'b0}) begin
            bad++; $display("FAIL basic_13div4 got q=%h r=%h err=%0b want q=03 r=01 err=0", q6, r6, err6);
        end
        @(negedge clk);
        total++; if (done6 !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got %0b want 0", done6); end
    endtask

    task automatic test_table;
        int ta[7] = '{13, -13, 13, -13, 7, -32, -32};
        int tb[7] = '{4, 4, -4, -4, 0, -1, 1};
        int tq[7] = '{3, 'h3D, 'h3D, 3, 0, 'h20, 'h20};
        int tr[7] = '{1, 'h3F, 1, 'h3F, 7, 0, 0};
        int te[7] = '{0, 0, 0, 0, 1, 1, 0};
        int lat, bc;
        for (int i = 0; i < 7; i++) begin
            go6(ta[i], tb[i]);
            wait6(lat, bc);
            total++; if (lat !== 7) begin bad++; $display("FAIL table_latency %0d/%0d got %0d want 7", ta[i], tb[i], lat); end
            total++; if ({q6, r6, err6} !== {6'(tq[i]), 6'(tr[i]), 1'(te[i])}) begin
                bad++; $display("FAIL table %0d/%0d got q=%h r=%h err=%0b want q=%h r=%h err=%0d",
                                ta[i], tb[i], q6, r6, err6, 6'(tq[i]), 6'(tr[i]), te[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat, bc;
        go6(5, 2);
        repeat (2) @(negedge clk);
        start6 = 1'b1; dvd6 = 6'd30; dvs6 = 6'd7;
        @(negedge clk);
        start6 = 1'b0;
        wait6(lat, bc);
        total++; if (lat !== 4) begin bad++; $display("FAIL ignore_latency got %0d want 4", lat); end
        total++; if ({q6, r6, err6} !== {6'd2, 6'd1, 1'b0}) begin
            bad++; $display("FAIL ignore_result got q=%h r=%h err=%0b want q=02 r=01 err=0", q6, r6, err6);
        end
        bc = 0;
        repeat (10) begin
            @(negedge clk);
            if (done6 === 1'b1 || busy6 === 1'b1) bc++;
        end
        total++; if (bc !== 0) begin bad++; $display("FAIL ignore_side_effect got %0d active cycles want 0", bc); end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        go6(13, 4);
        wait6(lat, bc);
        start6 = 1'b1; dvd6 = 6'd20; dvs6 = 6'd3;
        @(negedge clk);
        start6 = 1'b0; dvd6 = 6'd1; dvs6 = 6'd1;
        total++; if ({busy6, done6} !== 2'b10) begin
            bad++; $display("FAIL b2b_accept got busy=%0b done=%0b want busy=1 done=0", busy6, done6);
        end
        wait6(lat, bc);
        total++; if (lat !== 7) begin bad++; $display("FAIL b2b_latency got %0d want 7", lat); end
        total++; if ({q6, r6, err6} !== {6'd6, 6'd2, 1'b0}) begin
            bad++; $display("FAIL b2b_20div3 got q=%h r=%h err=%0b want q=06 r=02 err=0", q6, r6, err6);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        go6(13, 4);
        repeat (3) @(negedge clk);
        rst = 1'b1; start6 = 1'b1; dvd6 = 6'd9; dvs6 = 6'd2;
        @(negedge clk);
        total++; if ({busy6, done6, err6, q6, r6} !== 15'd0) begin
            bad++; $display("FAIL midreset_outputs got busy=%0b done=%0b err=%0b q=%h r=%h want all 0", busy6, done6, err6, q6, r6);
        end
        rst = 1'b0; start6 = 1'b0;
        bc = 0;
        repeat (12) begin
            @(negedge clk);
            if (done6 === 1'b1 || busy6 === 1'b1) bc++;
        end
        total++; if (bc !== 0) begin bad++; $display("FAIL midreset_no_done got %0d active cycles want 0", bc); end
        go6(9, 2);
        wait6(lat, bc);
        total++; if ({q6, r6, err6} !== {6'd4, 6'd1, 1'b0} || lat !== 7) begin
            bad++; $display("FAIL midreset_9div2 got q=%h r=%h err=%0b lat=%0d want q=04 r=01 err=0 lat=7", q6, r6, err6, lat);
        end
    endtask

    task automatic test_random6;
        int a, b, qe, re, ee, lat, bc;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 63)) - 32;
            b = int'($urandom_range(0, 63)) - 32;
            if (i % 10 == 0) b = 0;
            ref_div(a, b, 6, qe, re, ee);
            go6(a, b);
            wait6(lat, bc);
            total++; if ({q6, r6, err6} !== {6'(qe), 6'(re), 1'(ee)} || lat !== 7) begin
                bad++; $display("FAIL random6 %0d/%0d got q=%h r=%h err=%0b lat=%0d want q=%h r=%h err=%0d lat=7",
                                a, b, q6, r6, err6, lat, 6'(qe), 6'(re), ee);
            end
        end
    endtask

    task automatic test_sweep16;
        int cv[8] = '{0, 1, -1, 32767, -32767, -32768, 2, -2};
        int qe, re, ee, lat;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                ref_div(cv[i], cv[j], 16, qe, re, ee);
                go16(cv[i], cv[j]);
                wait16(lat);
                total++; if ({q16, r16, err16} !== {16'(qe), 16'(re), 1'(ee)} || lat !== 17) begin
                    bad++; $display("FAIL sweep16 %0d/%0d got q=%h r=%h err=%0b lat=%0d want q=%h r=%h err=%0d lat=17",
                                    cv[i], cv[j], q16, r16, err16, lat, 16'(qe), 16'(re), ee);
                end
            end
        end
        for (int k = 0; k < 20; k++) begin
            int a, b;
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 255)) - 128;
            ref_div(a, b, 16, qe, re, ee);
            go16(a, b);
            wait16(lat);
            total++; if ({q16, r16, err16} !== {16'(qe), 16'(re), 1'(ee)} || lat !== 17) begin
                bad++; $display("FAIL random16 %0d/%0d got q=%h r=%h err=%0b lat=%0d want q=%h r=%h err=%0d lat=17",
                                a, b, q16, r16, err16, lat, 16'(qe), 16'(re), ee);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start6 = 1'b0;  dvd6 = '0;  dvs6 = '0;
        start16 = 1'b0; dvd16 = '0; dvs16 = '0;
        test_reset;
        test_basic;
        test_table;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_random6;
        test_sweep16;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
